step_sequencer: RTL and testbench

//   Controller side of the cycle-timer interface (clrTimer out, timerDone in).
//   On start, emits numSteps step pulses, one per timer expiry.
//   Re-arms the external timer with a one-cycle clrTimer after each expiry.

---
 rtl/step_sequencer.sv | 91 +++++++++
 tb/tb_step_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - emits a fixed number of step pulses, one per external timer expiry
// Re-arms the external cycle timer with a one-cycle clear after every expiry.
module step_sequencer #(
   parameter int STEP_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [STEP_W-1:0] num_steps_i,
   input  logic              abort_i,
   input  logic              timer_done_i,
   output logic              clr_timer_o,
   output logic              step_pulse_o,
   output logic [STEP_W-1:0] step_count_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              step_pulse_q, step_pulse_d;
   logic [STEP_W-1:0] step_count_q, step_count_d;
   logic [STEP_W-1:0] target_q, target_d;
   logic [STEP_W-1:0] count_inc;

   // target never exceeds 2**STEP_W-1, so the increment cannot wrap
   assign count_inc = step_count_q + {{(STEP_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         step_pulse_q <= 1'b0;
         step_count_q <= '0;
         target_q     <= '0;
      end else begin
         state_q      <= state_d;
         step_pulse_q <= step_pulse_d;
         step_count_q <= step_count_d;
         target_q     <= target_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      step_pulse_d = 1'b0;
      step_count_d = step_count_q;
      target_d     = target_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               step_count_d = '0;
               if (num_steps_i != '0) begin
                  target_d = num_steps_i;
                  state_d  = ARM;
               end else begin
                  state_d  = DONE;
               end
            end
         end
         ARM:  state_d = WAIT;
         WAIT: begin
            if (timer_done_i) begin
               step_pulse_d = 1'b1;
               step_count_d = count_inc;
               state_d      = (count_inc == target_q) ? DONE : ARM;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort wins over a coincident expiry: no pulse, count frozen
      if (abort_i && (state_q != IDLE)) begin
         state_d      = IDLE;
         step_pulse_d = 1'b0;
         step_count_d = step_count_q;
      end
   end

   assign clr_timer_o  = (state_q != WAIT);
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign step_pulse_o = step_pulse_q;
   assign step_count_o = step_count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - directed bench for step_sequencer with a 3-cycle timer model
module tb_step_sequencer;
   localparam int STEP_W = 4;

   logic              clk = 1'b0;
   logic              rst, start, abort, force_td;
   logic [STEP_W-1:0] num_steps;
   logic              timer_done, clr_timer, step_pulse, busy, done;
   logic [STEP_W-1:0] step_count;
   logic [2:0]        tcnt = 3'd0;
   int                errors = 0;
   int                checks = 0;
   int                npulse;
   int                done_cyc;
   logic              saw_pulse, saw_done;

   step_sequencer #(.STEP_W(STEP_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .num_steps_i  (num_steps),
      .abort_i      (abort),
      .timer_done_i (timer_done),
      .clr_timer_o  (clr_timer),
      .step_pulse_o (step_pulse),
      .step_count_o (step_count),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   // external timer: expires two cycles after being released from clear
   always @(posedge clk) begin
      if (clr_timer || timer_done) tcnt <= 3'd0;
      else                         tcnt <= tcnt + 3'd1;
   end
   assign timer_done = (tcnt == 3'd2) || force_td;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; force_td = 1'b0; num_steps = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pulse", step_pulse, 0);
      check("rst_count", step_count, 0);
      check("rst_clr", clr_timer, 1);
      rst = 1'b0;
      tick();

      // three steps: pulses in cycles 5, 9, 13
      num_steps = 4'd3; start = 1'b1;
      tick();
      start = 1'b0; num_steps = 4'd9;
      for (int c = 1; c <= 16; c++) begin
         check($sformatf("n3_pulse_c%0d", c), step_pulse, (c == 5 || c == 9 || c == 13));
         check($sformatf("n3_done_c%0d", c), done, (c == 13));
         check($sformatf("n3_busy_c%0d", c), busy, (c <= 13));
         if (c == 13) check("n3_count_c13", step_count, 3);
         tick();
      end
      check("n3_count_hold", step_count, 3);

      // zero steps: straight to DONE
      num_steps = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("n0_busy_c1", busy, 1);
      check("n0_done_c1", done, 1);
      check("n0_pulse_c1", step_pulse, 0);
      check("n0_count_c1", step_count, 0);
      tick();
      check("n0_busy_c2", busy, 0);
      check("n0_done_c2", done, 0);
      check("n0_pulse_c2", step_pulse, 0);

      // abort coincident with the second expiry
      num_steps = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         if (c == 5) check("ab_pulse_c5", step_pulse, 1);
         tick();
      end
      check("ab_timer_c8", timer_done, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_busy_c9", busy, 0);
      check("ab_count_c9", step_count, 1);
      check("ab_pulse_c9", step_pulse, 0);
      saw_pulse = 1'b0; saw_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         saw_pulse |= step_pulse;
         saw_done  |= done;
         tick();
      end
      check("ab_no_pulse", saw_pulse, 0);
      check("ab_no_done", saw_done, 0);
      check("ab_count_hold", step_count, 1);

      // expiry forced while idle has no effect
      force_td = 1'b1;
      saw_pulse = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         saw_pulse |= step_pulse | busy;
      end
      force_td = 1'b0;
      check("idle_td_no_effect", saw_pulse, 0);
      check("idle_td_count", step_count, 1);
      tick();

      // fifteen steps with start pulses while busy
      num_steps = 4'd15; start = 1'b1;
      tick();
      start = 1'b0; num_steps = 4'd2;
      npulse = 0; done_cyc = 0;
      for (int c = 1; c <= 70; c++) begin
         if (step_pulse) npulse++;
         if (done) done_cyc = c;
         if (c == 61) check("n15_count_c61", step_count, 15);
         start = ((c % 7) == 0) && (c < 60);
         tick();
      end
      start = 1'b0;
      check("n15_pulses", npulse, 15);
      check("n15_done_cyc", done_cyc, 61);
      check("n15_count", step_count, 15);
      check("n15_busy", busy, 0);

      // reset in cycle 6 of a four-step run, then a clean rerun
      num_steps = 4'd4; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 5) check("r4_pulse_c5", step_pulse, 1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("r4_rst_busy", busy, 0);
      check("r4_rst_done", done, 0);
      check("r4_rst_pulse", step_pulse, 0);
      check("r4_rst_count", step_count, 0);
      check("r4_rst_clr", clr_timer, 1);
      num_steps = 4'd4; start = 1'b1;
      tick();
      start = 1'b0;
      npulse = 0;
      for (int c = 1; c <= 19; c++) begin
         check($sformatf("r4b_pulse_c%0d", c), step_pulse,
               ((c % 4) == 1) && (c >= 5) && (c <= 17));
         check($sformatf("r4b_done_c%0d", c), done, (c == 17));
         if (step_pulse) npulse++;
         tick();
      end
      check("r4b_pulses", npulse, 4);
      check("r4b_count", step_count, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
